// File: rtl/frame_pkg.sv
// Shared frame definitions for the serial frame receiver and frame_decoder.
// Command codes, frame field positions and the stereo sample payload.
package frame_pkg;

  localparam int unsigned FRAME_W  = 40;
  localparam int unsigned CMD_MSB  = 39;
  localparam int unsigned CMD_LSB  = 32;
  localparam int unsigned SAMPLE_W = 16;

  localparam logic [7:0] CMD_AUDIO = 8'hC7;
  localparam logic [7:0] CMD_CTRL  = 8'hC4;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_AUDIO = 2'd1,
    KIND_CTRL  = 2'd2,
    KIND_BAD   = 2'd3
  } frame_kind_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } sample_t;

  // Map a command byte onto the action the decoder takes for it.
  function automatic frame_kind_e classify(input logic [7:0] cmd);
    frame_kind_e kind;
    case (cmd)
      CMD_AUDIO: kind = KIND_AUDIO;
      CMD_CTRL:  kind = KIND_CTRL;
      default:   kind = KIND_BAD;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter.
module sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A pop on a full FIFO frees the slot the push lands in this same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/frame_decoder.sv
// Decodes strobed 40-bit frames into an audio sample FIFO, a control register
// and error/overflow flags. FRAME_DECODER_STATS_EN adds 16-bit event counters.
module frame_decoder
  import frame_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] CTRL_INIT = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FRAME_W-1:0]  frame_data,
  input  logic                frame_valid,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_left,
  output logic [SAMPLE_W-1:0] sample_right,
  output logic [15:0]         ctrl,
  output logic                ctrl_update,
  output logic                bad_cmd,
  output logic                overflow,
`ifdef FRAME_DECODER_STATS_EN
  output logic [15:0]         stat_frames,
  output logic [15:0]         stat_drops,
  output logic [15:0]         stat_bad,
`endif
  input  logic                ovf_clr
);

  logic        valid_q;
  logic        strobe;
  frame_kind_e kind;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        push;
  logic        drop;
  sample_t     wr_sample;
  sample_t     head;

  assign strobe = frame_valid & ~valid_q;
  assign pop    = sample_valid & sample_ready;

  // Decode of the command byte captured on the strobe edge.
  always_comb begin
    kind      = KIND_NONE;
    push      = 1'b0;
    drop      = 1'b0;
    wr_sample = frame_data[31:0];
    if (strobe) kind = classify(frame_data[CMD_MSB:CMD_LSB]);
    if (kind == KIND_AUDIO) begin
      push = ~fifo_full | pop;
      drop = fifo_full & ~pop;
    end
  end

  // valid_q follows frame_valid even in reset, so a level held across reset
  // is not mistaken for a fresh frame.
  always_ff @(posedge clk) begin
    valid_q <= frame_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl        <= CTRL_INIT;
      ctrl_update <= 1'b0;
      bad_cmd     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      ctrl_update <= (kind == KIND_CTRL);
      bad_cmd     <= (kind == KIND_BAD);
      if (kind == KIND_CTRL) ctrl <= frame_data[15:0];
      if (drop)              overflow <= 1'b1;
      else if (ovf_clr)      overflow <= 1'b0;
    end
  end

`ifdef FRAME_DECODER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames <= '0;
      stat_drops  <= '0;
      stat_bad    <= '0;
    end else begin
      if (strobe)            stat_frames <= stat_frames + 16'd1;
      if (drop)              stat_drops  <= stat_drops + 16'd1;
      if (kind == KIND_BAD)  stat_bad    <= stat_bad + 16'd1;
    end
  end
`endif

  sample_fifo #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_sample),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sample_valid = ~fifo_empty;
  assign sample_left  = head.left;
  assign sample_right = head.right;

endmodule

// File: tb/tb_frame_decoder.sv
// Self-checking bench for frame_decoder: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_frame_decoder;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [39:0] fd = '0;
  logic        fv = 1'b0;
  logic        rdy = 1'b0;
  logic        clr = 1'b0;
  logic        sample_valid;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic [15:0] ctrl;
  logic        ctrl_update;
  logic        bad_cmd;
  logic        overflow;
`ifdef FRAME_DECODER_STATS_EN
  logic [15:0] stat_frames;
  logic [15:0] stat_drops;
  logic [15:0] stat_bad;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] mq[$];
  logic [15:0] m_ctrl = 16'h0000;
  logic        m_upd = 1'b0;
  logic        m_bad = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_prev_fv = 1'b0;
  logic [15:0] m_frames = '0;
  logic [15:0] m_drops = '0;
  logic [15:0] m_badn = '0;

  always #5 clk = ~clk;

  frame_decoder #(.DEPTH(DEPTH), .CTRL_INIT(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst_i),
    .frame_data   (fd),
    .frame_valid  (fv),
    .sample_valid (sample_valid),
    .sample_ready (rdy),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .ctrl         (ctrl),
    .ctrl_update  (ctrl_update),
    .bad_cmd      (bad_cmd),
    .overflow     (overflow),
`ifdef FRAME_DECODER_STATS_EN
    .stat_frames  (stat_frames),
    .stat_drops   (stat_drops),
    .stat_bad     (stat_bad),
`endif
    .ovf_clr      (clr)
  );

  // Apply one clock of the specified behaviour to the model using current inputs.
  task automatic model_step();
    bit strobe, pop, full, set;
    if (rst_i) begin
      mq.delete();
      m_ctrl = 16'h0000; m_upd = 0; m_bad = 0; m_ovf = 0;
      m_frames = 0; m_drops = 0; m_badn = 0;
    end else begin
      strobe = fv && !m_prev_fv;
      pop    = (mq.size() > 0) && rdy;
      full   = (mq.size() == DEPTH);
      set = 0; m_upd = 0; m_bad = 0;
      if (pop) void'(mq.pop_front());
      if (strobe) begin
        m_frames++;
        if (fd[39:32] == 8'hC7) begin
          if (!full || pop) mq.push_back(fd[31:0]);
          else begin set = 1; m_drops++; end
        end else if (fd[39:32] == 8'hC4) begin
          m_ctrl = fd[15:0]; m_upd = 1;
        end else begin
          m_bad = 1; m_badn++;
        end
      end
      if (set) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    m_prev_fv = fv;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1; fv = 0; rdy = 0; clr = 0; fd = '0;
    tick();
    rst_i = 0;
  endtask

  function automatic logic [31:0] dval(input int i);
    return {16'(i * 16'h0101), 16'(16'hF000 + i)};
  endfunction

  task automatic push_audio(input logic [31:0] d);
    fv = 1; fd = {8'hC7, d};
    tick();
    fv = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL reset_ctrl got %h want 0000", ctrl); end
    checks++; if ({ctrl_update, bad_cmd, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ctrl_update, bad_cmd, overflow}); end
  endtask

  task automatic test_audio_basic();
    do_reset();
    fv = 1; fd = 40'hC7_1234_ABCD;
    tick();
    fv = 0;
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL audio_valid got %b want 1", sample_valid); end
    checks++; if ({sample_left, sample_right} !== 32'h1234_ABCD) begin errors++; $display("FAIL audio_data got %h want 1234abcd", {sample_left, sample_right}); end
    rdy = 1;
    tick();
    rdy = 0;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL audio_pop got %b want 0", sample_valid); end
  endtask

  task automatic test_ctrl_hold();
    int pulses = 0;
    do_reset();
    fv = 1; fd = 40'hC4_FFFF_00A5;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ctrl_update === 1'b1) pulses++;
    end
    fv = 0;
    tick();
    if (ctrl_update === 1'b1) pulses++;
    checks++; if (ctrl !== 16'h00A5) begin errors++; $display("FAIL ctrl_value got %h want 00a5", ctrl); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ctrl_pulses got %0d want 1", pulses); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL ctrl_fifo got %b want 0", sample_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      push_audio(dval(i));
      if (i == 8) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    clr = 1; tick(); clr = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
    rdy = 1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (sample_valid !== 1'b1 || {sample_left, sample_right} !== dval(i)) begin
        errors++; $display("FAIL ovf_order%0d got %b/%h want 1/%h", i, sample_valid, {sample_left, sample_right}, dval(i));
      end
      tick();
    end
    rdy = 0;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain got %b want 0", sample_valid); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 1; i <= 8; i++) push_audio(dval(i));
    rdy = 1; fv = 1; fd = 40'hC7_DEAD_BEEF;
    tick();
    fv = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
    for (int i = 2; i <= 8; i++) begin
      checks++;
      if (sample_valid !== 1'b1 || {sample_left, sample_right} !== dval(i)) begin
        errors++; $display("FAIL fullpop_order%0d got %b/%h want 1/%h", i, sample_valid, {sample_left, sample_right}, dval(i));
      end
      tick();
    end
    checks++; if (sample_valid !== 1'b1 || {sample_left, sample_right} !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL fullpop_last got %b/%h want 1/deadbeef", sample_valid, {sample_left, sample_right});
    end
    tick();
    rdy = 0;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b want 0", sample_valid); end
  endtask

  task automatic test_bad_cmd();
    do_reset();
    fv = 1; fd = 40'h55_0000_0000;
    tick();
    fv = 0;
    checks++; if (bad_cmd !== 1'b1) begin errors++; $display("FAIL bad_pulse got %b want 1", bad_cmd); end
    tick();
    checks++; if (bad_cmd !== 1'b0) begin errors++; $display("FAIL bad_clear got %b want 0", bad_cmd); end
    checks++; if (ctrl !== 16'h0000 || sample_valid !== 1'b0) begin errors++; $display("FAIL bad_state got %h/%b want 0000/0", ctrl, sample_valid); end
`ifdef FRAME_DECODER_STATS_EN
    checks++; if (stat_bad !== 16'd1 || stat_frames !== 16'd1) begin errors++; $display("FAIL bad_stats got %0d/%0d want 1/1", stat_bad, stat_frames); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    fv = 1; fd = 40'hC4_0000_1111; tick(); fv = 0; tick();
    for (int i = 1; i <= 3; i++) push_audio(dval(i));
    rst_i = 1; fv = 1; fd = 40'hC7_0BAD_0BAD;
    tick();
    rst_i = 0;
    tick(); tick();
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstmid_fifo got %b want 0", sample_valid); end
    checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL rstmid_ctrl got %h want 0000", ctrl); end
    fv = 0; tick();
    fv = 1; tick();
    checks++; if (sample_valid !== 1'b1 || {sample_left, sample_right} !== 32'h0BAD_0BAD) begin
      errors++; $display("FAIL rstmid_restrobe got %b/%h want 1/0bad0bad", sample_valid, {sample_left, sample_right});
    end
    fv = 0; tick();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) fv = ~fv;
      if (!fv || r == 9) begin
        r = int'($urandom_range(0, 9));
        fd = {(r < 6) ? 8'hC7 : (r < 8) ? 8'hC4 : 8'($urandom), 32'($urandom)};
      end
      rdy   = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      rst_i = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (sample_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc%0d got %b want %b", n, sample_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++;
        if ({sample_left, sample_right} !== mq[0]) begin errors++; $display("FAIL rnd_head cyc%0d got %h want %h", n, {sample_left, sample_right}, mq[0]); end
      end
      checks++;
      if ({ctrl, ctrl_update, bad_cmd, overflow} !== {m_ctrl, m_upd, m_bad, m_ovf}) begin
        errors++; $display("FAIL rnd_regs cyc%0d got %h/%b%b%b want %h/%b%b%b", n, ctrl, ctrl_update, bad_cmd, overflow, m_ctrl, m_upd, m_bad, m_ovf);
      end
`ifdef FRAME_DECODER_STATS_EN
      checks++;
      if ({stat_frames, stat_drops, stat_bad} !== {m_frames, m_drops, m_badn}) begin
        errors++; $display("FAIL rnd_stats cyc%0d got %0d/%0d/%0d want %0d/%0d/%0d", n, stat_frames, stat_drops, stat_bad, m_frames, m_drops, m_badn);
      end
`endif
    end
    rst_i = 0; fv = 0; rdy = 0; clr = 0;
  endtask

  initial begin
    test_reset();
    test_audio_basic();
    test_ctrl_hold();
    test_overflow();
    test_full_pop();
    test_bad_cmd();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
